// File: rtl/drum_mac_if.sv
// Operand/result stream bundle for drum_mac_pipe: operand beat in, product or running sum out.
interface drum_mac_if #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = A_W + B_W + 4
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             in_signed;
  logic             in_acc_en;
  logic             in_acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_acc_en, in_acc_clear, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_acc_en, in_acc_clear, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/drum_mac_pipe.sv
// Pipelined DRUM approximate multiplier with optional accumulate and sticky overflow.
// Registers: S1 (mantissas/shifts), S2 (product), S3 (signed result), output/accumulator.
module drum_mac_pipe #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 8,
  parameter int unsigned K     = 3,
  parameter int unsigned ACC_W = A_W + B_W + 4
) (
  input logic       clk,
  input logic       rst_n,
  drum_mac_if.slave bus
);
  localparam int unsigned TA_W = $clog2(A_W);
  localparam int unsigned TB_W = $clog2(B_W);
  localparam int unsigned SH_W = $clog2(A_W + B_W + 1);
  localparam int unsigned P_W  = 2 * K;

  logic             adv;
  logic             neg_a, neg_b;
  logic [A_W-1:0]   mag_a;
  logic [B_W-1:0]   mag_b;
  logic [TA_W-1:0]  ta, sh_a;
  logic [TB_W-1:0]  tb, sh_b;
  logic [K-1:0]     m_a, m_b;

  logic             s1_valid, s1_neg, s1_en, s1_clr;
  logic [K-1:0]     s1_ma, s1_mb;
  logic [TA_W-1:0]  s1_sha;
  logic [TB_W-1:0]  s1_shb;

  logic             s2_valid, s2_neg, s2_en, s2_clr;
  logic [P_W-1:0]   s2_prod;
  logic [SH_W-1:0]  s2_sh;

  logic             s3_valid, s3_en, s3_clr;
  logic [ACC_W-1:0] s3_r;

  logic             res_valid, res_ovf;
  logic [ACC_W-1:0] res_data;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  logic [ACC_W-1:0] shifted, sum;
  logic             add_ovf;

  assign adv           = !res_valid || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = res_valid;
  assign bus.out_data  = res_data;
  assign bus.out_ovf   = res_ovf;

  // One's-complement magnitude, leading-one position and K-bit DRUM mantissa per operand.
  always_comb begin
    neg_a = bus.in_signed & bus.in_a[A_W-1];
    neg_b = bus.in_signed & bus.in_b[B_W-1];
    mag_a = neg_a ? ~bus.in_a : bus.in_a;
    mag_b = neg_b ? ~bus.in_b : bus.in_b;
    ta = '0;
    tb = '0;
    for (int i = 0; i < A_W; i++) if (mag_a[i]) ta = TA_W'(i);
    for (int i = 0; i < B_W; i++) if (mag_b[i]) tb = TB_W'(i);
    if (ta <= TA_W'(K - 1)) begin
      m_a  = mag_a[K-1:0];
      sh_a = '0;
    end else begin
      m_a  = {mag_a[ta -: (K - 1)], 1'b1};
      sh_a = ta - TA_W'(K - 1);
    end
    if (tb <= TB_W'(K - 1)) begin
      m_b  = mag_b[K-1:0];
      sh_b = '0;
    end else begin
      m_b  = {mag_b[tb -: (K - 1)], 1'b1};
      sh_b = tb - TB_W'(K - 1);
    end
  end

  // Shift/sign for S3 and signed-overflow detection for the accumulate add.
  always_comb begin
    shifted = ACC_W'(s2_prod) << s2_sh;
    sum     = acc + s3_r;
    add_ovf = (acc[ACC_W-1] == s3_r[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovf   <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_ma    <= m_a;
      s1_mb    <= m_b;
      s1_sha   <= sh_a;
      s1_shb   <= sh_b;
      s1_neg   <= neg_a ^ neg_b;
      s1_en    <= bus.in_acc_en;
      s1_clr   <= bus.in_acc_clear;

      s2_valid <= s1_valid;
      s2_prod  <= P_W'(s1_ma) * P_W'(s1_mb);
      s2_sh    <= SH_W'(s1_sha) + SH_W'(s1_shb);
      s2_neg   <= s1_neg;
      s2_en    <= s1_en;
      s2_clr   <= s1_clr;

      s3_valid <= s2_valid;
      s3_r     <= s2_neg ? ~shifted : shifted;
      s3_en    <= s2_en;
      s3_clr   <= s2_clr;

      // Accumulator state moves only when a real beat enters the output register.
      res_valid <= s3_valid;
      if (s3_valid) begin
        if (!s3_en) begin
          res_data <= s3_r;
          res_ovf  <= ovf;
        end else if (s3_clr) begin
          acc      <= s3_r;
          ovf      <= 1'b0;
          res_data <= s3_r;
          res_ovf  <= 1'b0;
        end else begin
          acc      <= sum;
          ovf      <= ovf | add_ovf;
          res_data <= sum;
          res_ovf  <= ovf | add_ovf;
        end
      end
    end
  end
endmodule
